// File: rtl/axis_stream_checker.sv
// AXI-stream sink that compares received beats against a FIFO of expected {last, data} bytes.
// Define CHECKER_STALL_LFSR_EN to add pseudo-random backpressure on tready while running.
module axis_stream_checker #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     op_en,
  input  logic [7:0]               Din,
  input  logic                     Din_last,
  input  logic                     push,
  output logic [$clog2(DEPTH):0]   buff_count,
  output logic                     full,
  output logic                     empty,
  input  logic [7:0]               tdata,
  input  logic                     tvalid,
  output logic                     tready,
  input  logic                     tlast,
  output logic [CW-1:0]            match_count,
  output logic [CW-1:0]            err_count,
  output logic [CW-1:0]            pkt_count,
  output logic                     pkt_done,
  output logic                     err_flag,
  output logic                     ovf_flag,
  output logic [8:0]               err_exp,
  output logic [8:0]               err_got
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e state_q, state_d;
  logic   tready_q, tready_d;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic          cmp_vld_q, cmp_vld_d;
  logic          cmp_unexp_q, cmp_unexp_d;
  logic [8:0]    cmp_exp_q, cmp_exp_d;
  logic [8:0]    cmp_got_q, cmp_got_d;

  logic [CW-1:0] match_q, match_d, err_q, err_d, pkt_q, pkt_d;
  logic          pkt_done_q, pkt_done_d;
  logic          err_flag_q, err_flag_d;
  logic          ovf_q, ovf_d;
  logic [8:0]    err_exp_q, err_exp_d, err_got_q, err_got_d;

  logic accept, pop, push_ok, ovf_set;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (op_en) state_d = StRun;
      StRun:   if (!op_en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (clear) state_d = StIdle;
  end

`ifdef CHECKER_STALL_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == StRun) lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    if (clear) lfsr_d = 16'hACE1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Output logic: registered tready, throttled by the LFSR
  always_comb begin
    tready_d = (state_d == StRun) & lfsr_d[0];
  end
`else
  // Output logic: registered tready, one cycle behind op_en
  always_comb begin
    tready_d = (state_d == StRun);
  end
`endif

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  assign accept  = tvalid & tready_q;
  assign pop     = accept & ~empty;
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr_q] <= {Din_last, Din};
  end

  // Accepted beat and its expected head are latched; counters settle one cycle later
  always_comb begin
    cmp_vld_d   = accept & ~clear;
    cmp_unexp_d = empty;
    cmp_exp_d   = empty ? 9'h1FF : mem[rd_ptr_q];
    cmp_got_d   = {tlast, tdata};

    match_d    = match_q;
    err_d      = err_q;
    err_flag_d = err_flag_q;
    err_exp_d  = err_exp_q;
    err_got_d  = err_got_q;
    if (cmp_vld_q) begin
      if (!cmp_unexp_q && (cmp_exp_q == cmp_got_q)) begin
        match_d = sat_inc(match_q);
      end else begin
        err_d      = sat_inc(err_q);
        err_flag_d = 1'b1;
        if (!err_flag_q) begin
          err_exp_d = cmp_exp_q;
          err_got_d = cmp_got_q;
        end
      end
    end

    pkt_d      = (accept & tlast) ? sat_inc(pkt_q) : pkt_q;
    pkt_done_d = accept & tlast;
    ovf_d      = ovf_q | ovf_set;

    if (clear) begin
      cmp_vld_d  = 1'b0;
      match_d    = '0;
      err_d      = '0;
      pkt_d      = '0;
      pkt_done_d = 1'b0;
      err_flag_d = 1'b0;
      ovf_d      = 1'b0;
      err_exp_d  = '0;
      err_got_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tready_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmp_vld_q   <= 1'b0;
      cmp_unexp_q <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_got_q   <= '0;
      match_q     <= '0;
      err_q       <= '0;
      pkt_q       <= '0;
      pkt_done_q  <= 1'b0;
      err_flag_q  <= 1'b0;
      ovf_q       <= 1'b0;
      err_exp_q   <= '0;
      err_got_q   <= '0;
    end else begin
      tready_q    <= tready_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_unexp_q <= cmp_unexp_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_got_q   <= cmp_got_d;
      match_q     <= match_d;
      err_q       <= err_d;
      pkt_q       <= pkt_d;
      pkt_done_q  <= pkt_done_d;
      err_flag_q  <= err_flag_d;
      ovf_q       <= ovf_d;
      err_exp_q   <= err_exp_d;
      err_got_q   <= err_got_d;
    end
  end

  assign tready      = tready_q;
  assign buff_count  = count_q;
  assign match_count = match_q;
  assign err_count   = err_q;
  assign pkt_count   = pkt_q;
  assign pkt_done    = pkt_done_q;
  assign err_flag    = err_flag_q;
  assign ovf_flag    = ovf_q;
  assign err_exp     = err_exp_q;
  assign err_got     = err_got_q;

endmodule

// File: tb/tb_axis_stream_checker.sv
// Randomized self-checking bench for axis_stream_checker against a queue-based reference model.
module tb_axis_stream_checker;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 16;

  logic                  clk = 1'b0;
  logic                  rst, clear, op_en, push, Din_last;
  logic [7:0]            Din, tdata;
  logic                  tvalid, tlast;
  logic [$clog2(DEPTH):0] buff_count;
  logic                  full, empty, tready, pkt_done, err_flag, ovf_flag;
  logic [CW-1:0]         match_count, err_count, pkt_count;
  logic [8:0]            err_exp, err_got;

  axis_stream_checker #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .op_en(op_en),
    .Din(Din), .Din_last(Din_last), .push(push),
    .buff_count(buff_count), .full(full), .empty(empty),
    .tdata(tdata), .tvalid(tvalid), .tready(tready), .tlast(tlast),
    .match_count(match_count), .err_count(err_count), .pkt_count(pkt_count),
    .pkt_done(pkt_done), .err_flag(err_flag), .ovf_flag(ovf_flag),
    .err_exp(err_exp), .err_got(err_got)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: expected queue plus scoreboard counts
  logic [8:0] mq[$];
  int         m_match, m_err, m_pkt;
  bit         m_eflag, m_ovf;
  logic [8:0] m_exp, m_got;

  int pd_seen = 0;
  int stall_cycles = 0;
  bit stall_window = 1'b0;

  always @(negedge clk) begin
    if (rst && pkt_done) pd_seen++;
    if (stall_window && !tready) stall_cycles++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_match = 0; m_err = 0; m_pkt = 0;
    m_eflag = 1'b0; m_ovf = 1'b0;
    m_exp = '0; m_got = '0;
  endfunction

  function automatic void model_accept(input logic [7:0] d, input logic l);
    logic [8:0] got, exp;
    bit         bad;
    got = {l, d};
    if (mq.size() == 0) begin
      exp = 9'h1FF;
      bad = 1'b1;
    end else begin
      exp = mq.pop_front();
      bad = (exp != got);
    end
    if (bad) begin
      m_err++;
      if (!m_eflag) begin
        m_exp = exp;
        m_got = got;
      end
      m_eflag = 1'b1;
    end else begin
      m_match++;
    end
    if (l) m_pkt++;
  endfunction

  function automatic void model_push(input logic [7:0] d, input logic l);
    if (mq.size() < DEPTH) mq.push_back({l, d});
    else m_ovf = 1'b1;
  endfunction

  task automatic push_byte(input logic [7:0] d, input logic l);
    Din = d; Din_last = l; push = 1'b1;
    @(negedge clk);
    push = 1'b0;
    model_push(d, l);
  endtask

  // Present a beat and hold it until accepted; optionally push in the accept cycle
  task automatic send_beat(input logic [7:0] d, input logic l, input bit wp,
                           input logic [7:0] pd, input logic pl);
    bit ok = 1'b0;
    tdata = d; tlast = l; tvalid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (tready === 1'b1) begin
        if (wp) begin
          Din = pd; Din_last = pl; push = 1'b1;
        end
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (ok) begin
      @(negedge clk);
      tvalid = 1'b0; push = 1'b0;
      model_accept(d, l);
      if (wp) model_push(pd, pl);
    end else begin
      tvalid = 1'b0;
      check_eq("beat_timeout", 0, 1);
    end
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic do_clear();
    settle();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    pd_seen = 0;
  endtask

  task automatic check_all(input string pre);
    check_eq({pre, "_match"}, 32'(match_count), 32'(m_match));
    check_eq({pre, "_err"},   32'(err_count),   32'(m_err));
    check_eq({pre, "_pkt"},   32'(pkt_count),   32'(m_pkt));
    check_eq({pre, "_eflag"}, 32'(err_flag),    32'(m_eflag));
    check_eq({pre, "_ovf"},   32'(ovf_flag),    32'(m_ovf));
    check_eq({pre, "_exp"},   32'(err_exp),     32'(m_exp));
    check_eq({pre, "_got"},   32'(err_got),     32'(m_got));
    check_eq({pre, "_cnt"},   32'(buff_count),  32'(mq.size()));
    check_eq({pre, "_full"},  32'(full),        32'(mq.size() == DEPTH));
    check_eq({pre, "_empty"}, 32'(empty),       32'(mq.size() == 0));
    check_eq({pre, "_pdone"}, 32'(pd_seen),     32'(m_pkt));
  endtask

  task automatic check_zero(input string pre);
    check_eq({pre, "_z_cnt"},   32'(buff_count),  0);
    check_eq({pre, "_z_match"}, 32'(match_count), 0);
    check_eq({pre, "_z_err"},   32'(err_count),   0);
    check_eq({pre, "_z_pkt"},   32'(pkt_count),   0);
    check_eq({pre, "_z_flags"}, {28'd0, tready, pkt_done, err_flag, ovf_flag}, 0);
    check_eq({pre, "_z_exp"},   32'(err_exp),     0);
    check_eq({pre, "_z_got"},   32'(err_got),     0);
    check_eq({pre, "_z_empty"}, 32'(empty),       1);
  endtask

  initial begin
    logic [7:0] d;
    logic       l;
    rst = 1'b0; clear = 1'b0; op_en = 1'b0; push = 1'b0;
    Din = '0; Din_last = 1'b0; tdata = '0; tvalid = 1'b0; tlast = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Matching packet of three beats
    push_byte(8'hA5, 1'b0);
    push_byte(8'h3C, 1'b0);
    push_byte(8'h7E, 1'b1);
    op_en = 1'b1;
    send_beat(8'hA5, 1'b0, 1'b0, 8'h00, 1'b0);
    send_beat(8'h3C, 1'b0, 1'b0, 8'h00, 1'b0);
    send_beat(8'h7E, 1'b1, 1'b0, 8'h00, 1'b0);
    settle();
    check_all("t1");
    check_eq("t1_match3", 32'(match_count), 3);

    // Mismatch, then a second mismatch that must not recapture
    do_clear();
    push_byte(8'h11, 1'b0);
    send_beat(8'h12, 1'b0, 1'b0, 8'h00, 1'b0);
    settle();
    check_all("t2a");
    check_eq("t2_exp", 32'(err_exp), 32'h011);
    check_eq("t2_got", 32'(err_got), 32'h012);
    push_byte(8'h20, 1'b0);
    send_beat(8'h21, 1'b0, 1'b0, 8'h00, 1'b0);
    settle();
    check_all("t2b");

    // Unexpected beat on an empty FIFO
    do_clear();
    send_beat(8'h55, 1'b1, 1'b0, 8'h00, 1'b0);
    settle();
    check_all("t3");
    check_eq("t3_exp", 32'(err_exp), 32'h1FF);
    check_eq("t3_got", 32'(err_got), 32'h155);

    // Overflow, then push with simultaneous pop while full
    do_clear();
    op_en = 1'b0;
    for (int i = 0; i <= DEPTH; i++) push_byte(8'($urandom), 1'($urandom_range(0, 1)));
    settle();
    check_all("t4a");
    op_en = 1'b1;
    send_beat(mq[0][7:0], mq[0][8], 1'b1, 8'hC3, 1'b0);
    settle();
    check_all("t4b");

    // Backpressure: op_en low freezes the sink, the held beat is accepted later
    do_clear();
    push_byte(8'h42, 1'b0);
    op_en = 1'b0;
    repeat (3) @(negedge clk);
    tdata = 8'h42; tlast = 1'b0; tvalid = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("t5_tready", 32'(tready), 0);
    check_all("t5a");
    op_en = 1'b1;
    send_beat(8'h42, 1'b0, 1'b0, 8'h00, 1'b0);
    settle();
    check_all("t5b");

    // Randomized traffic: mostly matching beats, some corrupted or unexpected
    do_clear();
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 9) < 5) begin
        push_byte(8'($urandom), ($urandom_range(0, 3) == 0));
      end else begin
        if (mq.size() > 0 && $urandom_range(0, 7) != 0) begin
          d = mq[0][7:0];
          l = mq[0][8];
        end else begin
          d = 8'($urandom);
          l = 1'($urandom_range(0, 1));
        end
        send_beat(d, l, 1'b0, 8'h00, 1'b0);
      end
      if (it % 40 == 39) begin
        settle();
        check_all("rnd");
      end
    end

    // Asynchronous reset mid-stream with entries queued
    do_clear();
    push_byte(8'h01, 1'b0);
    send_beat(8'h02, 1'b1, 1'b0, 8'h00, 1'b0);
    push_byte(8'h03, 1'b0);
    push_byte(8'h04, 1'b0);
    push_byte(8'h05, 1'b1);
    settle();
    check_all("pre_rst");
    #2 rst = 1'b0;
    #1 check_zero("arst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    pd_seen = 0;

    // Synchronous clear mid-stream
    push_byte(8'h0A, 1'b0);
    send_beat(8'h0B, 1'b1, 1'b0, 8'h00, 1'b0);
    push_byte(8'h0C, 1'b0);
    push_byte(8'h0D, 1'b0);
    push_byte(8'h0E, 1'b1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_zero("sclr");
    model_reset();
    pd_seen = 0;

`ifdef CHECKER_STALL_LFSR_EN
    // Pseudo-random backpressure while running
    op_en = 1'b1;
    settle();
    stall_cycles = 0;
    stall_window = 1'b1;
    for (int i = 0; i < 200; i++) begin
      d = 8'($urandom);
      l = 1'($urandom_range(0, 1));
      push_byte(d, l);
      send_beat(d, l, 1'b0, 8'h00, 1'b0);
    end
    stall_window = 1'b0;
    settle();
    check_all("lfsr");
    check_eq("lfsr_match200", 32'(match_count), 200);
    check_eq("lfsr_stall_seen", 32'(stall_cycles > 0), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_stream_checker.md
Name: axis_stream_checker

Overview:
- Downstream consumer for the AXI-stream data port (m_axis_data_*) of an i2c_slave or i2c_master.
- Holds a FIFO of expected bytes, loaded with the same push interface as stream_gen.
- Accepts received beats and compares each against the FIFO head, data and tlast both.
- Keeps match, error and packet counters for self-checking I2C benches.

Parameters:
- DEPTH, 8: expected-FIFO depth in entries; power of two, 2..256.
- CW, 16: width of match_count, err_count and pkt_count.

Ports:
- clk in 1: clock.
- rst in 1: asynchronous active-low reset.
- clear in 1: synchronous clear of FIFO, counters and flags.
- op_en in 1: checker enable; gates tready.
- Din in 8: expected byte.
- Din_last in 1: expected tlast for this byte.
- push in 1: write {Din_last, Din} into the FIFO.
- buff_count out $clog2(DEPTH)+1: expected-FIFO occupancy.
- full out 1: FIFO full.
- empty out 1: FIFO empty.
- tdata in 8: received stream data.
- tvalid in 1: received stream valid.
- tready out 1: checker ready.
- tlast in 1: received stream last.
- match_count out CW: beats with data and last both matching.
- err_count out CW: mismatched plus unexpected beats.
- pkt_count out CW: received beats with tlast=1.
- pkt_done out 1: one-cycle pulse after a tlast beat is accepted.
- err_flag out 1: sticky, set on any error.
- ovf_flag out 1: sticky, set on push while full without pop.
- err_exp out 9: {last, data} expected at the first error.
- err_got out 9: {last, data} received at the first error.

Behaviour:
- Reset (rst=0, async): FIFO empty, all counters 0, all flags 0, err_exp/err_got 0, tready 0, pkt_done 0, state IDLE.
- clear=1: same effect as reset, applied synchronously; takes priority over push and accept in that cycle.
- States:
  - IDLE: tready=0. Go to RUN when op_en=1.
  - RUN: tready=1 registered. Go to IDLE when op_en=0.
  - tready follows op_en with one cycle of latency. A beat already presented is never lost; it simply waits while tready=0.
- Accept = tvalid & tready.
- On accept with FIFO not empty:
  - Pop the FIFO head.
  - If {tlast, tdata} equals the head: match_count+1.
  - Otherwise: err_count+1 and err_flag=1.
- On accept with FIFO empty (unexpected beat): err_count+1, err_flag=1, err_exp=9'h1FF.
- err_exp/err_got capture only while err_flag=0, i.e. the first error only.
- Accept with tlast=1: pkt_count+1 and pkt_done=1 on the following cycle, whether or not the beat matched.
- FIFO push:
  - Write when push=1 and (not full, or pop in the same cycle). Full plus simultaneous pop is accepted and count is unchanged.
  - Push while full with no pop: data dropped, ovf_flag=1.
  - Push with simultaneous pop while empty: the beat is unexpected, and the pushed byte is stored (count becomes 1).
- Pointers wrap modulo DEPTH. buff_count ranges 0..DEPTH. full = (buff_count==DEPTH); empty = (buff_count==0).
- Counters saturate at all-ones and never wrap.
- All outputs are registered except full and empty, which decode buff_count.
- Comparison is made against the head registered at accept time. Compare result shows on the counters one cycle after accept.

Optional Feature:
- Macro CHECKER_STALL_LFSR_EN.
- Defined: in RUN, tready is additionally ANDed with bit 0 of a 16-bit Fibonacci LFSR.
  - Polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset/clear.
  - LFSR advances every cycle in RUN.
  - Gives pseudo-random backpressure to stress the I2C core's m_axis buffering.
- Undefined: tready depends on state only; no LFSR logic present.

Test Plan:
- Push 8'hA5, 8'h3C, 8'h7E (last=1 on 7E); op_en=1; send matching beats -> match_count=3, err_count=0, pkt_count=1, pkt_done pulses once, buff_count=0.
- Push 8'h11 (last=0); send tdata=8'h12, tlast=0 -> err_count=1, err_flag=1, err_exp=9'h011, err_got=9'h012. A second mismatch leaves err_exp/err_got unchanged.
- Empty FIFO; send beat 8'h55, tlast=1 -> err_count=1, err_exp=9'h1FF, err_got=9'h155, pkt_count=1.
- Push DEPTH+1 bytes with no beats -> buff_count=DEPTH, full=1, ovf_flag=1. Then push and accept in the same cycle -> buff_count stays DEPTH, ovf_flag stays 1.
- Mid-stream with 3 entries queued: pulse rst low -> all outputs 0 at once. Pulse clear -> same result on the next edge.
- op_en=0 with tvalid held high -> tready=0 and counters frozen. With the macro on, 200 matching beats -> match_count=200, err_count=0, and at least one tready=0 cycle in RUN.
